// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the write-back port arbiter and the WB stage wiring.
package wb_port_arbiter_pkg;

    localparam int WB_DW       = 32;
    localparam int WB_AW       = 5;
    localparam int WB_DEPTH    = 4;
    localparam int WB_MAX_WAIT = 8;

    // Register 0 is hard-wired; writes to it are never issued.
    localparam logic [WB_AW-1:0] REG_ZERO = '0;

    // One write-back request as seen by the WB stage.
    typedef struct packed {
        logic [WB_DW-1:0] data;
        logic [WB_AW-1:0] addr;
        logic             wr;
    } wb_req_t;

    // Which source owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_LLU  = 2'd2
    } gnt_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the pipeline/LLU side and the write-back port arbiter.
interface wb_port_arbiter_if
    import wb_port_arbiter_pkg::*;
#(
    parameter int DW    = WB_DW,
    parameter int AW    = WB_AW,
    parameter int DEPTH = WB_DEPTH
);
    logic                     hold;
    logic                     pipe_valid;
    logic [DW-1:0]            pipe_data;
    logic [AW-1:0]            pipe_addr;
    logic                     pipe_wr;
    logic                     llu_valid;
    logic                     llu_ready;
    logic [DW-1:0]            llu_data;
    logic [AW-1:0]            llu_addr;
    logic [DW-1:0]            wb_data;
    logic [AW-1:0]            wb_addr;
    logic                     wb_wr;
    logic                     wb_we;
    logic                     stall_req;
    logic [(2**AW)-1:0]       pend_mask;
    logic [$clog2(DEPTH):0]   fifo_count;

    // Pipeline / LLU side: drives requests, observes the write port.
    modport master (
        output hold, pipe_valid, pipe_data, pipe_addr, pipe_wr,
        output llu_valid, llu_data, llu_addr,
        input  llu_ready, wb_data, wb_addr, wb_wr, wb_we,
        input  stall_req, pend_mask, fifo_count
    );

    // Arbiter side.
    modport slave (
        input  hold, pipe_valid, pipe_data, pipe_addr, pipe_wr,
        input  llu_valid, llu_data, llu_addr,
        output llu_ready, wb_data, wb_addr, wb_wr, wb_we,
        output stall_req, pend_mask, fifo_count
    );

endinterface

// File: rtl/wb_llu_fifo.sv
// Result buffer for the long-latency unit: storage, pointers, occupancy and
// the pending-destination mask used by hazard detection.
module wb_llu_fifo #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_enq,
    input  logic [DW-1:0]            i_data,
    input  logic [AW-1:0]            i_addr,
    input  logic                     i_deq,
    output logic [DW-1:0]            o_head_data,
    output logic [AW-1:0]            o_head_addr,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [(2**AW)-1:0]       o_pend_mask
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0]    r_data [DEPTH];
    logic [AW-1:0]    r_addr [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_enq;
    logic             w_do_deq;
    logic [(2**AW)-1:0] w_mask;

    assign o_full      = (r_count == FULL_CNT);
    assign o_empty     = (r_count == '0);
    assign w_do_enq    = i_enq & ~o_full;
    assign w_do_deq    = i_deq & ~o_empty;
    assign o_head_data = r_data[r_rd_ptr];
    assign o_head_addr = r_addr[r_rd_ptr];
    assign o_count     = r_count;
    assign o_pend_mask = w_mask;

    // Pointers, occupancy and per-entry valid flags; pointers wrap at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else begin
            if (w_do_enq) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_do_deq) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + PW'(1);
            end
            case ({w_do_enq, w_do_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage; contents are qualified by r_vld so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_do_enq) begin
            r_data[r_wr_ptr] <= i_data;
            r_addr[r_wr_ptr] <= i_addr;
        end
    end

    // One-hot destination of every valid entry, OR-ed together.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i]) begin
                w_mask[r_addr[i]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the in-order
// pipeline and buffered long-latency-unit results.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DW       = WB_DW,
    parameter int AW       = WB_AW,
    parameter int DEPTH    = WB_DEPTH,
    parameter int MAX_WAIT = WB_MAX_WAIT
) (
    input  logic                clk,
    input  logic                reset,
    wb_port_arbiter_if.slave    bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT);

    logic               w_pipe_need;
    logic               w_wait_hit;
    logic               w_enq;
    logic               w_deq;
    logic               w_full;
    logic               w_empty;
    logic [DW-1:0]      w_head_data;
    logic [AW-1:0]      w_head_addr;
    logic [CW-1:0]      w_count;
    logic [(2**AW)-1:0] w_pend;
    logic [WW-1:0]      r_wait;
    gnt_e               w_gnt;
    wb_req_t            w_req;
    logic               w_stall;

    assign w_pipe_need   = bus.pipe_valid & bus.pipe_wr & (bus.pipe_addr != REG_ZERO);
    assign w_wait_hit    = (r_wait == WAIT_SAT);
    // Readiness looks only at the registered count, never at a same-cycle drain.
    assign bus.llu_ready = ~reset & ~w_full;
    // Results for register 0 are accepted but never stored.
    assign w_enq         = bus.llu_valid & bus.llu_ready & (bus.llu_addr != REG_ZERO);
    assign w_deq         = (w_gnt == GNT_LLU);

    wb_llu_fifo #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_llu_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_enq       (w_enq),
        .i_data      (bus.llu_data),
        .i_addr      (bus.llu_addr),
        .i_deq       (w_deq),
        .o_head_data (w_head_data),
        .o_head_addr (w_head_addr),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_pend_mask (w_pend)
    );

    // Grant decision and write-port mux; the LLU preempts the pipeline only
    // when the pipeline would not write, the head has aged out, or the FIFO is full.
    always_comb begin
        w_gnt   = GNT_NONE;
        w_req   = '0;
        w_stall = 1'b0;
        if (!reset && !bus.hold) begin
            if (!w_empty && (!w_pipe_need || w_wait_hit || w_full)) begin
                w_gnt      = GNT_LLU;
                w_req.data = w_head_data;
                w_req.addr = w_head_addr;
                w_req.wr   = 1'b1;
                w_stall    = w_pipe_need;
            end else if (bus.pipe_valid) begin
                w_gnt      = GNT_PIPE;
                w_req.data = bus.pipe_data;
                w_req.addr = bus.pipe_addr;
                w_req.wr   = w_pipe_need;
            end
        end
    end

    // Age of the FIFO head; frozen under hold, cleared when empty or drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait <= '0;
        end else if (!bus.hold) begin
            if (w_empty || w_deq) begin
                r_wait <= '0;
            end else if (!w_wait_hit) begin
                r_wait <= r_wait + WW'(1);
            end
        end
    end

    assign bus.wb_data    = w_req.data;
    assign bus.wb_addr    = w_req.addr;
    assign bus.wb_wr      = w_req.wr;
    assign bus.wb_we      = ~reset & ~bus.hold;
    assign bus.stall_req  = w_stall;
    assign bus.pend_mask  = reset ? '0 : w_pend;
    assign bus.fifo_count = reset ? '0 : w_count;

endmodule
